// File: rtl/full_adder_behavioral.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_behavioral
// Description : Full adder built as a WIDTH-bit ripple-carry chain.
//               {carry_out, sum} = a + b + carry_in (unsigned, no saturation).
//               With REG_OUT=1 the outputs are registered: one cycle of
//               latency and an asynchronous active-high reset. With
//               REG_OUT=0 the outputs are purely combinational, and clk and
//               rst have no effect.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_behavioral #(
    parameter int WIDTH   = 1,  // legal range 1..64
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Ripple carry chain. w_carry[0] is the carry into bit 0, and
    // w_carry[WIDTH] is the carry out of the most significant bit.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = carry_in;

    // One full-adder cell per bit. The logic is written with plain bitwise
    // operators so that an X on any input reaches only the outputs that
    // depend on it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi])
                                   | (a[gi] & w_carry[gi])
                                   | (b[gi] & w_carry[gi]);
        end
    endgenerate

    generate
        if (REG_OUT) begin : g_reg_out
            logic [WIDTH-1:0] r_sum;
            logic             r_carry_out;

            // Capture the combinational result on each rising edge. Reset
            // clears the outputs at once, without waiting for a clock edge,
            // which also discards any result that was in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sum       <= '0;
                    r_carry_out <= 1'b0;
                end else begin
                    r_sum       <= w_sum;
                    r_carry_out <= w_carry[WIDTH];
                end
            end

            assign sum       = r_sum;
            assign carry_out = r_carry_out;
        end else begin : g_comb_out
            // clk and rst have no function in this mode. They are folded
            // into a signal that is intentionally left unused.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;

            assign sum       = w_sum;
            assign carry_out = w_carry[WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_full_adder_behavioral.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder_behavioral
// Description : Directed self-checking bench for full_adder_behavioral.
//               It covers three instances: registered 1-bit, combinational
//               1-bit, and registered 4-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_behavioral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Registered 1-bit instance
    logic       a1, b1, cin1, s1, co1;
    // Combinational 1-bit instance
    logic       a0, b0, cin0, s0, co0;
    // Registered 4-bit instance
    logic [3:0] a4, b4, s4;
    logic       cin4, co4;

    int checks = 0;
    int errors = 0;

    // Hand-written truth table, indexed by {a, b, cin}
    logic [7:0] sum_tbl  = 8'b1001_0110;
    logic [7:0] cout_tbl = 8'b1110_1000;

    always #5 clk = ~clk;

    full_adder_behavioral #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .carry_in(cin1),
        .sum(s1), .carry_out(co1));

    full_adder_behavioral #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .rst(rst), .a(a0), .b(b0), .carry_in(cin0),
        .sum(s0), .carry_out(co0));

    full_adder_behavioral #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .carry_in(cin4),
        .sum(s4), .carry_out(co4));

    // Hold reset with active inputs, then release it and expect 1+1+1.
    task automatic test_reset();
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({co1, s1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold_w1 cycle %0d got cout=%b sum=%b exp cout=0 sum=0", k, co1, s1);
            end
            checks++;
            if ({co4, s4} !== 5'd0) begin
                errors++;
                $display("FAIL reset_hold_w4 cycle %0d got cout=%b sum=%0d exp cout=0 sum=0", k, co4, s4);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({co1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_before_edge got cout=%b sum=%b exp cout=0 sum=0", co1, s1);
        end
        @(posedge clk); #1;
        checks++;
        if ({co1, s1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_first_edge got cout=%b sum=%b exp cout=1 sum=1", co1, s1);
        end
    endtask

    // Step through all 8 input patterns; each result shows up one edge later.
    task automatic test_sweep_reg_w1();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            {a1, b1, cin1} = v;
            @(posedge clk); #1;
            checks++;
            if (s1 !== sum_tbl[i]) begin
                errors++;
                $display("FAIL sweep_reg_sum in=%b got %b exp %b", v, s1, sum_tbl[i]);
            end
            checks++;
            if (co1 !== cout_tbl[i]) begin
                errors++;
                $display("FAIL sweep_reg_cout in=%b got %b exp %b", v, co1, cout_tbl[i]);
            end
        end
    endtask

    // Combinational instance: outputs must follow the inputs in the same time step.
    task automatic test_comb_w1();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a0, b0, cin0} = v;
            #1;
            checks++;
            if (s0 !== sum_tbl[i]) begin
                errors++;
                $display("FAIL comb_sum in=%b got %b exp %b", v, s0, sum_tbl[i]);
            end
            checks++;
            if (co0 !== cout_tbl[i]) begin
                errors++;
                $display("FAIL comb_cout in=%b got %b exp %b", v, co0, cout_tbl[i]);
            end
        end
    endtask

    // 4-bit vectors, including the all-ones wrap-around case.
    task automatic test_w4_vectors();
        logic [3:0] va [3] = '{4'd15, 4'd15, 4'd5};
        logic [3:0] vb [3] = '{4'd1,  4'd15, 4'd6};
        logic       vc [3] = '{1'b0,  1'b1,  1'b1};
        logic [3:0] es [3] = '{4'd0,  4'd15, 4'd12};
        logic       ec [3] = '{1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = va[i]; b4 = vb[i]; cin4 = vc[i];
            @(posedge clk); #1;
            checks++;
            if (s4 !== es[i]) begin
                errors++;
                $display("FAIL w4_sum vec %0d got %0d exp %0d", i, s4, es[i]);
            end
            checks++;
            if (co4 !== ec[i]) begin
                errors++;
                $display("FAIL w4_cout vec %0d got %b exp %b", i, co4, ec[i]);
            end
        end
    endtask

    // Assert reset between edges while showing 12; outputs must clear without a clock edge.
    task automatic test_reset_mid();
        checks++;
        if ({co4, s4} !== {1'b0, 4'd12}) begin
            errors++;
            $display("FAIL mid_pre got cout=%b sum=%0d exp cout=0 sum=12", co4, s4);
        end
        #1;
        rst = 1'b1;
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b1;
        #1;
        checks++;
        if ({co4, s4} !== 5'd0) begin
            errors++;
            $display("FAIL mid_async_clear got cout=%b sum=%0d exp cout=0 sum=0", co4, s4);
        end
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== 5'd0) begin
            errors++;
            $display("FAIL mid_hold got cout=%b sum=%0d exp cout=0 sum=0", co4, s4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({co4, s4} !== 5'd0) begin
            errors++;
            $display("FAIL mid_release_before_edge got cout=%b sum=%0d exp cout=0 sum=0", co4, s4);
        end
        @(posedge clk); #1;
        checks++;
        if ({co4, s4} !== {1'b0, 4'd8}) begin
            errors++;
            $display("FAIL mid_first_edge got cout=%b sum=%0d exp cout=0 sum=8", co4, s4);
        end
    endtask

    initial begin
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a0 = 1'b0; b0 = 1'b0; cin0 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0;
        #1;
        test_reset();
        test_sweep_reg_w1();
        test_comb_w1();
        test_w4_vectors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/full_adder_behavioral.md
Name: full_adder_behavioral

Overview:
- Registered one-bit full adder, extendable to a WIDTH-bit ripple adder by parameter.
- Adds a, b and carry_in, and produces sum and carry_out.
- Used as a leaf arithmetic cell in datapaths and as the reference adder for bench bring-up.
- Output registers sit on clk, with an asynchronous active-high reset.

Parameters:
- WIDTH, 1: bit width of a, b and sum. carry_in and carry_out are always 1 bit. Legal range is 1..64.
- REG_OUT, 1:
  - 1: sum and carry_out are registered, with 1-cycle latency.
  - 0: sum and carry_out are purely combinational, and clk and rst are ignored.

Ports:
- clk  input  1  rising-edge clock for the output registers.
- rst  input  1  asynchronous, active-high reset of the output registers.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- carry_in  input  1  carry into bit 0.
- sum  output  WIDTH  low WIDTH bits of a+b+carry_in.
- carry_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- Arithmetic:
  - {carry_out, sum} = a + b + carry_in, computed at WIDTH+1 bits, unsigned, with no saturation.
  - Per bit i: s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i. c_0 is carry_in and carry_out is c_WIDTH.
- WIDTH=1 truth table (a b cin -> sum cout):
  - 000->0 0, 001->1 0, 010->1 0, 011->0 1
  - 100->1 0, 101->0 1, 110->0 1, 111->1 1
- REG_OUT=1:
  - On each rising clk edge, sum and carry_out capture the combinational result of the inputs sampled at that edge.
  - Latency is exactly 1 cycle. A new result is produced every cycle and there is no handshake.
  - rst=1 forces sum=0 and carry_out=0 immediately, without waiting for clk.
  - Outputs hold 0 while rst is high, whatever the input activity.
  - The first clk edge after rst deasserts loads the current sum.
  - Reset mid-operation: any in-flight result is discarded and outputs read 0 until the next post-reset edge.
- REG_OUT=0:
  - Outputs follow inputs combinationally with zero latency.
  - rst has no effect, and the outputs have no reset value.
- Wrap-around: the all-ones + all-ones + 1 case gives sum = all-ones and carry_out = 1. Overflow is reported only through carry_out.
- X on any input bit propagates to the dependent output bits. No X-masking is done.
- There is no internal state beyond the output registers.

Test Plan:
- REG_OUT=1, WIDTH=1: hold rst=1 and apply a=1, b=1, carry_in=1 -> sum=0 and carry_out=0 throughout. Deassert rst; after 1 edge -> sum=1, carry_out=1.
- REG_OUT=1, WIDTH=1: sweep all 8 input combinations, one per cycle. Each result appears one edge later and matches the truth table, e.g. 011 -> sum=0, cout=1 and 100 -> sum=1, cout=0.
- REG_OUT=0, WIDTH=1: apply the 8 combinations at 1-time-unit spacing with no clock -> outputs match the truth table in the same time step, e.g. 101 -> sum=0, cout=1.
- REG_OUT=1, WIDTH=4: a=15, b=1, carry_in=0 -> sum=0, carry_out=1. Then a=15, b=15, carry_in=1 -> sum=15, carry_out=1. Then a=5, b=6, carry_in=1 -> sum=12, carry_out=0.
- REG_OUT=1, WIDTH=4: with outputs showing sum=12, assert rst between edges -> sum=0 and carry_out=0 immediately, before the next clk edge. Release rst -> the next edge loads the current input result.
